// File: rtl/ppu_pixel_fifo_if.sv
// Renderer/scan-out side signals of the PPU pixel FIFO.
// The renderer and VGA controller together act as master; the FIFO is the slave.
interface ppu_pixel_fifo_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 6
) ();
    logic          frame_start;
    logic          pixel_we;
    logic [DW-1:0] pixel_idx;
    logic          fifo_re;
    logic          clear_err;
    logic [DW-1:0] palette_disp_idx;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output frame_start, pixel_we, pixel_idx, fifo_re, clear_err,
        input  palette_disp_idx, full, empty, count, overflow, underflow
    );

    modport slave (
        input  frame_start, pixel_we, pixel_idx, fifo_re, clear_err,
        output palette_disp_idx, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// First-word-fall-through palette-index FIFO between the PPU renderer and VGA scan-out.
// Head word, fill level and sticky error flags are all registered outputs.
module ppu_pixel_fifo #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    ppu_pixel_fifo_if.slave  bus
);
    localparam int unsigned CW       = AW + 1;
    localparam logic [DW-1:0] BLACK  = DW'(6'h0F);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [DW-1:0] head_q, head_d;
    logic          push_ok_c;
    logic          pop_ok_c;

    // Next-state: accepted push/pop, pointer/count update, flags, and next head word.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_ok_c   = 1'b0;
        pop_ok_c    = 1'b0;

        if (bus.frame_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            pop_ok_c  = bus.fifo_re && !empty_q;
            // When full, a same-cycle pop frees the slot the push lands in.
            push_ok_c = bus.pixel_we && (!full_q || pop_ok_c);
            if (push_ok_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok_c, pop_ok_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (bus.clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!bus.frame_start && bus.pixel_we && full_q && !pop_ok_c) begin
            overflow_d = 1'b1;
        end
        if (!bus.frame_start && bus.fifo_re && empty_q) begin
            underflow_d = 1'b1;
        end

        full_d  = (count_d == FULL_N);
        empty_d = (count_d == '0);

        // The word being written this cycle is not yet in mem_q, so forward it.
        if (empty_d) begin
            head_d = BLACK;
        end else if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = bus.pixel_idx;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            head_q      <= BLACK;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            head_q      <= head_d;
        end
    end

    // Storage array carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= bus.pixel_idx;
        end
    end

    assign bus.palette_disp_idx = head_q;
    assign bus.full             = full_q;
    assign bus.empty            = empty_q;
    assign bus.count            = count_q;
    assign bus.overflow         = overflow_q;
    assign bus.underflow        = underflow_q;

endmodule
